// File: rtl/handshake_rx_fifo.sv
// rtl/handshake_rx_fifo.sv - 4-phase req/ack receive stage buffering tokens into a valid/ready FIFO
//
// Ports:
//   clk        single clock, all state on the rising edge
//   rst_n      asynchronous active-low reset
//   req_i1     4-phase request from the upstream controller (asynchronous to clk)
//   dat_i1     bundled data, stable from req_i1 rise until ack_i1 rise
//   ack_i1     4-phase acknowledge back to the upstream controller (registered)
//   out_data   FIFO head entry
//   out_valid  FIFO non-empty
//   out_ready  consumer accepts the head when out_valid is high
//   level      current FIFO occupancy, 0..DEPTH

module handshake_rx_fifo #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_i1,
    input  logic [WIDTH-1:0]           dat_i1,
    output logic                       ack_i1,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(DEPTH);

    typedef enum logic {
        IDLE  = 1'b0,
        ACKED = 1'b1
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   req_s;
    logic [WIDTH-1:0]       mem [DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic                   push;
    logic                   pop;

    // req_i1 is only ever observed through this chain; req_s is the last stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], req_i1};
        end
    end

    assign req_s = sync_q[SYNC_STAGES-1];

    // The full check uses the registered level, so a same-edge pop never
    // makes room for a push.
    assign push      = (state == IDLE) && req_s && (level != FULL_LEVEL);
    assign out_valid = (level != '0);
    assign pop       = out_valid && out_ready;
    assign out_data  = mem[rd_ptr];

    // Handshake FSM: one write per 4-phase cycle, ack raised on the write edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            ack_i1 <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (push) begin
                        ack_i1 <= 1'b1;
                        state  <= ACKED;
                    end
                end
                ACKED: begin
                    if (!req_s) begin
                        ack_i1 <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    ack_i1 <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    // Storage is cleared on reset so out_data reads zero while empty after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= dat_i1;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: tb/tb_handshake_rx_fifo.sv
// tb/tb_handshake_rx_fifo.sv - directed self-checking bench for handshake_rx_fifo

module tb_handshake_rx_fifo;

    logic       clk;
    logic       rst_n;
    logic       req_i1;
    logic [7:0] dat_i1;
    logic       ack_i1;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] level;

    int n_checks;
    int n_fail;

    logic       mon_en;
    logic [7:0] popped [$];
    int         max_level;

    handshake_rx_fifo #(
        .WIDTH       (8),
        .DEPTH       (4),
        .SYNC_STAGES (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i1    (req_i1),
        .dat_i1    (dat_i1),
        .ack_i1    (ack_i1),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and sample 1 time unit later; optionally log pops.
    task automatic tick();
        if (mon_en && out_valid && out_ready) popped.push_back(out_data);
        @(posedge clk);
        #1;
        if (mon_en && int'(level) > max_level) max_level = int'(level);
    endtask

    task automatic handshake(input logic [7:0] d);
        int n;
        dat_i1 = d;
        req_i1 = 1'b1;
        n = 0;
        while (!ack_i1 && n < 20) begin
            tick();
            n++;
        end
        check("hs_ack_rise", ack_i1, 1);
        req_i1 = 1'b0;
        n = 0;
        while (ack_i1 && n < 20) begin
            tick();
            n++;
        end
        check("hs_ack_fall", ack_i1, 0);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        mon_en    = 1'b0;
        max_level = 0;
        rst_n     = 1'b0;
        req_i1    = 1'b0;
        dat_i1    = 8'h00;
        out_ready = 1'b0;

        // Reset state
        repeat (2) tick();
        check("rst_ack", ack_i1, 0);
        check("rst_valid", out_valid, 0);
        check("rst_level", level, 0);
        check("rst_data", out_data, 8'h00);
        rst_n = 1'b1;

        // Single token: ack on the third edge after req rise
        dat_i1 = 8'hA5;
        req_i1 = 1'b1;
        tick();
        tick();
        check("t1_ack_edge2", ack_i1, 0);
        check("t1_valid_edge2", out_valid, 0);
        tick();
        check("t1_ack_edge3", ack_i1, 1);
        check("t1_valid", out_valid, 1);
        check("t1_data", out_data, 8'hA5);
        check("t1_level", level, 1);
        dat_i1 = 8'hFF;
        req_i1 = 1'b0;
        tick();
        tick();
        check("t1_ackfall_edge2", ack_i1, 1);
        tick();
        check("t1_ackfall_edge3", ack_i1, 0);
        check("t1_data_held", out_data, 8'hA5);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("t1_pop_valid", out_valid, 0);
        check("t1_pop_level", level, 0);
        tick();
        check("t1_no_underflow", level, 0);

        // Fill and backpressure
        handshake(8'h01);
        handshake(8'h02);
        handshake(8'h03);
        handshake(8'h04);
        check("fill_level4", level, 4);
        dat_i1 = 8'h05;
        req_i1 = 1'b1;
        repeat (6) tick();
        check("full_ack_held", ack_i1, 0);
        check("full_level", level, 4);
        check("full_head", out_data, 8'h01);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("full_pop_level", level, 3);
        check("full_pop_noack", ack_i1, 0);
        check("full_pop_head", out_data, 8'h02);
        tick();
        check("full_late_ack", ack_i1, 1);
        check("full_late_level", level, 4);
        req_i1 = 1'b0;
        repeat (3) tick();
        check("full_ack_drop", ack_i1, 0);
        check("drain_02", out_data, 8'h02);
        out_ready = 1'b1;
        tick();
        check("drain_03", out_data, 8'h03);
        tick();
        check("drain_04", out_data, 8'h04);
        tick();
        check("drain_05", out_data, 8'h05);
        tick();
        out_ready = 1'b0;
        check("drain_level", level, 0);
        check("drain_valid", out_valid, 0);

        // Wrap-around with continuous consumer
        out_ready = 1'b1;
        mon_en    = 1'b1;
        max_level = 0;
        for (int i = 0; i < 10; i++) begin
            handshake(i[7:0]);
        end
        repeat (4) tick();
        mon_en    = 1'b0;
        out_ready = 1'b0;
        check("wrap_count", popped.size(), 10);
        for (int i = 0; i < popped.size() && i < 10; i++) begin
            check($sformatf("wrap_data_%0d", i), popped[i], i);
        end
        check("wrap_max_level_le2", (max_level <= 2), 1);
        check("wrap_level_end", level, 0);

        // Simultaneous push and pop at level 2
        handshake(8'h20);
        handshake(8'h21);
        check("sim_level2", level, 2);
        dat_i1 = 8'h22;
        req_i1 = 1'b1;
        tick();
        tick();
        check("sim_pre_ack", ack_i1, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("sim_ack", ack_i1, 1);
        check("sim_level", level, 2);
        check("sim_head", out_data, 8'h21);
        req_i1 = 1'b0;
        repeat (3) tick();
        out_ready = 1'b1;
        tick();
        check("sim_next", out_data, 8'h22);
        tick();
        out_ready = 1'b0;
        check("sim_empty", level, 0);

        // Request held high long after ack: exactly one write
        dat_i1 = 8'h33;
        req_i1 = 1'b1;
        repeat (3) tick();
        check("hold_ack", ack_i1, 1);
        repeat (20) tick();
        check("hold_level", level, 1);
        check("hold_ack_still", ack_i1, 1);
        req_i1 = 1'b0;
        repeat (3) tick();
        check("hold_ack_fall", ack_i1, 0);
        check("hold_data", out_data, 8'h33);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("hold_empty", level, 0);

        // Asynchronous reset mid-handshake
        handshake(8'h40);
        handshake(8'h41);
        dat_i1 = 8'h42;
        req_i1 = 1'b1;
        repeat (3) tick();
        check("mrst_pre_ack", ack_i1, 1);
        check("mrst_pre_level", level, 3);
        #3;
        rst_n = 1'b0;
        #1;
        check("mrst_ack", ack_i1, 0);
        check("mrst_valid", out_valid, 0);
        check("mrst_level", level, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        tick();
        check("mrst_re_ack_edge2", ack_i1, 0);
        tick();
        check("mrst_re_ack_edge3", ack_i1, 1);
        check("mrst_re_level", level, 1);
        check("mrst_re_data", out_data, 8'h42);
        req_i1 = 1'b0;
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/handshake_rx_fifo.md
Name: handshake_rx_fifo

Overview:
- Clocked receive stage directly downstream of the 4-phase req/ack handshake controller.
- Consumes the controller's outgoing request (req_i1) and the bundled data, and returns the acknowledge (ack_i1).
- Synchronises the request into the clock domain and buffers each token in a small FIFO.
- Presents buffered tokens to synchronous logic over a valid/ready interface.

Parameters:
- WIDTH, 8: bundled data width in bits.
- DEPTH, 4: FIFO entries; power of two, at least 2.
- SYNC_STAGES, 2: flip-flops in the req_i1 synchroniser; at least 2.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_i1  input  1  4-phase request from upstream controller; asynchronous to clk.
- dat_i1  input  WIDTH  bundled data; stable from req_i1 rise until ack_i1 rise.
- ack_i1  output  1  4-phase acknowledge to upstream controller; registered.
- out_data  output  WIDTH  FIFO head entry.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts head when out_valid is high.
- level  output  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. Ports are clk and rst_n.
- Reset (asynchronous assert, synchronous release):
  - ack_i1=0, out_valid=0, level=0.
  - Read and write pointers 0; synchroniser flops 0; FSM in IDLE.
  - out_data = 0 (storage cleared).
- Synchroniser: req_i1 passes through SYNC_STAGES flops; req_s is the last stage. No other logic samples req_i1 directly.
- FSM states: IDLE, ACKED.
  - IDLE, req_s=1 and level<DEPTH: write dat_i1 at wr_ptr, advance wr_ptr, set ack_i1=1, go to ACKED. All happen on the same edge.
  - IDLE, req_s=1 and level==DEPTH: hold. ack_i1 stays 0 and no write occurs (backpressure). Capture happens on the first edge where level<DEPTH.
  - IDLE, req_s=0: hold.
  - ACKED, req_s=0: set ack_i1=0, go to IDLE.
  - ACKED, req_s=1: hold ack_i1=1. No second write; exactly one token per 4-phase cycle.
- Latency:
  - req_i1 rise to ack_i1 rise: SYNC_STAGES+1 rising edges when not full.
  - req_i1 fall to ack_i1 fall: SYNC_STAGES+1 edges.
  - out_valid and level update on the same edge as the write.
- Read side:
  - out_data = mem[rd_ptr], combinational from registers.
  - Pop when out_valid && out_ready: advance rd_ptr, decrement level.
  - out_ready while empty is ignored; no underflow.
- Simultaneous push and pop:
  - Both occur and level is unchanged.
  - The full check uses the registered level, so a push is refused when level==DEPTH even if a pop happens the same edge.
  - With DEPTH=1 occupancy the pushed token becomes visible on the following cycle.
- Pointers: wrap modulo DEPTH. level ranges 0..DEPTH and never exceeds DEPTH.
- Data is captured from dat_i1 on the write edge only; later changes to dat_i1 have no effect.
- Reset mid-handshake:
  - ack_i1 drops immediately and FIFO contents are discarded.
  - If req_i1 is still high after release, it is treated as a new token and re-captured after SYNC_STAGES+1 edges.
- Ordering: strict FIFO; tokens leave in arrival order.

Test Plan:
- Single token: rst_n released, req_i1 rises with dat_i1=8'hA5 → ack_i1=1 on edge 3 and out_valid=1, out_data=8'hA5, level=1. req_i1 falls → ack_i1=0 on edge 3 after the fall. out_ready=1 → out_valid=0, level=0.
- Fill: out_ready=0, four handshakes with data 01,02,03,04 → level=4. A fifth req_i1 rise with 05 → ack_i1 stays 0. One pop returns 01, then ack_i1 rises and level returns to 4. Drain order is 02,03,04,05.
- Wrap-around: 10 handshakes (data 0..9) with out_ready=1 continuously → outputs 0..9 in order, level never exceeds 2, no token lost or duplicated.
- Simultaneous push/pop: level=2, pop and write on the same edge → level stays 2, and out_data advances to the next older entry.
- Req held high after ack: req_i1 held high for 20 cycles after ack_i1=1 → exactly one write, level=1.
- Reset mid-operation: level=3 and state ACKED, pulse rst_n low asynchronously mid-cycle → ack_i1=0, out_valid=0, level=0 immediately. With req_i1 still high, ack_i1 rises 3 edges after release and level=1.
